// File: rtl/uart_tx_pkg.sv
// Typed view of the shared UART defines plus the data-bit-count clamp.
package uart_tx_pkg;
`include "define_uart.vh"

    localparam int NUMB_BIT_MAX = `UART_NUMB_BIT_MAX;
    localparam int NBIT_WD      = `UART_NUMB_BIT_WD;
    localparam int DIV_WD       = `UART_NUMB_DIV_CLK_WD;
    localparam int PAR_WD       = `UART_ENUM_PARITY_WD;
    localparam int STOP_WD      = `UART_SIZE_STOP_WD;
    localparam int STATE_WD     = `UART_STATE_WD;

    localparam logic [PAR_WD-1:0]  PAR_NONE = `UART_PARITY_NONE;
    localparam logic [PAR_WD-1:0]  PAR_ODD  = `UART_PARITY_ODD;
    localparam logic [PAR_WD-1:0]  PAR_EVEN = `UART_PARITY_EVEN;
    localparam logic [STOP_WD-1:0] STOP_2   = `UART_STOP_2;

    typedef enum logic [STATE_WD-1:0] {
        ST_IDLE   = `UART_STATE_IDLE,
        ST_START  = `UART_STATE_START,
        ST_DATA   = `UART_STATE_DATA,
        ST_PARITY = `UART_STATE_PARITY,
        ST_STOP   = `UART_STATE_STOP
    } uart_state_e;

    function automatic logic [NBIT_WD-1:0] clamp_nbit(input logic [NBIT_WD-1:0] n);
        if (n < NBIT_WD'(5))
            return NBIT_WD'(5);
        if (n > NBIT_WD'(NUMB_BIT_MAX))
            return NBIT_WD'(NUMB_BIT_MAX);
        return n;
    endfunction
endpackage

// File: rtl/define_uart.vh
// Shared UART widths and encodings for the transmitter and receiver.
`ifndef DEFINE_UART_VH
`define DEFINE_UART_VH

`define UART_NUMB_BIT_MAX      8
`define UART_NUMB_BIT_WD       4
`define UART_NUMB_DIV_CLK_WD   16

`define UART_ENUM_PARITY_WD    2
`define UART_PARITY_NONE       2'd0
`define UART_PARITY_ODD        2'd1
`define UART_PARITY_EVEN       2'd2

`define UART_SIZE_STOP_WD      1
`define UART_STOP_1            1'b0
`define UART_STOP_2            1'b1

`define UART_STATE_WD          3
`define UART_STATE_IDLE        3'd0
`define UART_STATE_START       3'd1
`define UART_STATE_DATA        3'd2
`define UART_STATE_PARITY      3'd3
`define UART_STATE_STOP        3'd4

`endif

// File: rtl/uart_bit_timer.sv
// Bit-period counter: eob_o pulses in the last cycle of each div_i+1 cycle period while enabled.
// clr_i restarts the period; shared between transmitter and receiver.
module uart_bit_timer #(
    parameter int CNT_WD = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic [CNT_WD-1:0] div_i,
    output logic              eob_o
);

    logic [CNT_WD-1:0] cnt_q, cnt_d;

    always_comb begin
        eob_o = en_i && (cnt_q == div_i);
        cnt_d = cnt_q + CNT_WD'(1);
        if (clr_i || !en_i || eob_o)
            cnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 5..MAX data bits LSB first, optional parity, 1 or 2 stop bits.
// Config is captured on accept; rdy_o also rises in the final stop cycle for gapless frames.
module uart_tx
    import uart_tx_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DIV_WD-1:0]       cfg_num_div_clk_i,
    input  logic [NBIT_WD-1:0]      cfg_num_bit_i,
    input  logic [PAR_WD-1:0]       cfg_enm_parity_i,
    input  logic [STOP_WD-1:0]      cfg_siz_stop_i,
    input  logic                    val_i,
    input  logic [NUMB_BIT_MAX-1:0] dat_i,
    output logic                    rdy_o,
    output logic                    uart_tx_o,
    output logic                    busy_o
);

    uart_state_e               state_q, state_d;
    logic [DIV_WD-1:0]         div_q, div_d;
    logic [NBIT_WD-1:0]        nbit_q, nbit_d;
    logic [PAR_WD-1:0]         par_q, par_d;
    logic                      stop2_q, stop2_d;
    logic [NUMB_BIT_MAX-1:0]   shift_q, shift_d;
    logic [NBIT_WD-1:0]        bit_cnt_q, bit_cnt_d;
    logic                      parity_q, parity_d;
    logic                      line_q, line_d;

    logic eob;
    logic last_stop;
    logic accept;

    uart_bit_timer #(
        .CNT_WD (DIV_WD)
    ) u_bit_timer (
        .clk   (clk),
        .rst   (rst),
        .en_i  (state_q != ST_IDLE),
        .clr_i (accept),
        .div_i (div_q),
        .eob_o (eob)
    );

    // In STOP, bit_cnt counts stop bits already completed.
    assign last_stop = (state_q == ST_STOP) && eob && (!stop2_q || (bit_cnt_q == NBIT_WD'(1)));
    assign rdy_o     = (state_q == ST_IDLE) || last_stop;
    assign accept    = val_i && rdy_o;
    assign busy_o    = (state_q != ST_IDLE);
    assign uart_tx_o = line_q;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        nbit_d    = nbit_q;
        par_d     = par_q;
        stop2_d   = stop2_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;
        line_d    = line_q;

        case (state_q)
            ST_IDLE: begin
                line_d = 1'b1;
            end
            ST_START: begin
                if (eob) begin
                    state_d   = ST_DATA;
                    line_d    = shift_q[0];
                    parity_d  = shift_q[0];
                    shift_d   = {1'b0, shift_q[NUMB_BIT_MAX-1:1]};
                    bit_cnt_d = NBIT_WD'(1);
                end
            end
            ST_DATA: begin
                if (eob) begin
                    if (bit_cnt_q == nbit_q) begin
                        bit_cnt_d = '0;
                        if (par_q != PAR_NONE) begin
                            state_d = ST_PARITY;
                            line_d  = (par_q == PAR_ODD) ? ~parity_q : parity_q;
                        end else begin
                            state_d = ST_STOP;
                            line_d  = 1'b1;
                        end
                    end else begin
                        line_d    = shift_q[0];
                        parity_d  = parity_q ^ shift_q[0];
                        shift_d   = {1'b0, shift_q[NUMB_BIT_MAX-1:1]};
                        bit_cnt_d = bit_cnt_q + NBIT_WD'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (eob) begin
                    state_d   = ST_STOP;
                    line_d    = 1'b1;
                    bit_cnt_d = '0;
                end
            end
            ST_STOP: begin
                if (last_stop) begin
                    state_d = ST_IDLE;
                    line_d  = 1'b1;
                end else if (eob) begin
                    bit_cnt_d = NBIT_WD'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                line_d  = 1'b1;
            end
        endcase

        if (accept) begin
            state_d   = ST_START;
            line_d    = 1'b0;
            div_d     = cfg_num_div_clk_i;
            nbit_d    = clamp_nbit(cfg_num_bit_i);
            par_d     = ((cfg_enm_parity_i == PAR_ODD) || (cfg_enm_parity_i == PAR_EVEN))
                        ? cfg_enm_parity_i : PAR_NONE;
            stop2_d   = (cfg_siz_stop_i == STOP_2);
            shift_d   = dat_i;
            bit_cnt_d = '0;
            parity_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            nbit_q    <= '0;
            par_q     <= PAR_NONE;
            stop2_q   <= 1'b0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
            line_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            nbit_q    <= nbit_d;
            par_q     <= par_d;
            stop2_q   <= stop2_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            parity_q  <= parity_d;
            line_q    <= line_d;
        end
    end

endmodule
